// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer.
// Holds the FSM state encoding, the abort-cause codes reported on o_err_code,
// the default frame-start marker and small helpers for parameter-derived widths.
package uart_cmd_pkg;

  // FSM state encoding (3 bits, also exported on the debug state output)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_WRITE = 3'd5;

  // Abort causes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CHK     = 2'b11;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Allowed inter-byte gap expressed in system clock cycles.
  function automatic int timeout_ticks(input int clk_rate, input int baud_rate,
                                       input int bits);
    return (clk_rate / baud_rate) * bits;
  endfunction

  // Index width needed to address a MAX_LEN-entry payload buffer (at least 1).
  function automatic int buf_idx_w(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Register-bus write port driven by the command sequencer.
//   wr_en    : write request (valid)
//   wr_addr  : write address
//   wr_data  : write data
//   wr_ready : register port accepts the write this cycle
// Handshake: a word transfers on every rising clk edge where wr_en && wr_ready.
// While wr_en is high and wr_ready low, the master keeps wr_addr/wr_data stable
// and does not drop wr_en; the slave may raise wr_ready at any time.
interface uart_cmd_sequencer_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_cmd_sequencer_cmd_payload_buf.sv
// Payload buffer: MAX_LEN x 8-bit register file.
//   clk   : system clock
//   we    : write enable (synchronous write of wdata at idx)
//   idx   : shared read/write index
//   wdata : byte to store
//   rdata : byte at idx (asynchronous read)
// Contents are not reset; the sequencer only reads entries it has written.
module cmd_payload_buf
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int IW      = buf_idx_w(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: parses SYNC, ADDR, LEN, DATA x LEN [, CHK] frames from
// the UART receiver byte stream, buffers the payload and replays it as
// sequential register writes (base+i, data[i]) over a valid/ready port.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   i_rx_data/_done    : received byte and its one-cycle strobe
//   i_rx_receiving     : receiver mid-byte, holds the inter-byte timeout at 0
//   wr                 : register write port (master side)
//   o_busy             : any state other than IDLE
//   o_frame_ok/_err    : one-cycle completion / abort pulses
//   o_err_code         : cause of the last abort (held until the next abort)
//   o_overrun          : a byte arrived during WRITE and was dropped
//   o_dbg_state        : current FSM state
// Optional feature macro: UART_CMD_CHECKSUM_EN adds a trailing CHK byte that must
// equal ADDR ^ LEN ^ DATA[0] ^ ... ^ DATA[LEN-1].
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_RATE     = 100_000_000,
  parameter int         BAUD_RATE    = 9_600,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_rx_receiving,
  uart_cmd_sequencer_if.master        wr,
  output logic                        o_busy,
  output logic                        o_frame_ok,
  output logic                        o_frame_err,
  output logic [1:0]                  o_err_code,
  output logic                        o_overrun,
  output logic [2:0]                  o_dbg_state
);

  localparam int TIMEOUT_TICKS = timeout_ticks(CLK_RATE, BAUD_RATE, TIMEOUT_BITS);
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam int IW = buf_idx_w(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state;
  logic [7:0]    base;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_data;
  logic          in_parse;
  logic          in_write;
  logic          tmo_hit;
  logic          last_idx;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]    chk_acc;
`endif

  assign in_parse = (state == ST_ADDR) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CHK);
  assign in_write = (state == ST_WRITE);
  assign last_idx = (idx == len - 8'd1);
  // Receiver activity also suppresses the abort, matching the counter hold.
  assign tmo_hit  = (tmo_cnt == TMO_LAST) && !i_rx_receiving;

  cmd_payload_buf #(.MAX_LEN(MAX_LEN), .IW(IW)) u_buf (
    .clk   (clk),
    .we    ((state == ST_DATA) && i_rx_done),
    .idx   (idx[IW-1:0]),
    .wdata (i_rx_data),
    .rdata (rd_data)
  );

  // Address/data are forced to 0 outside WRITE so idle outputs never expose
  // stale buffer contents.
  assign wr.wr_en     = in_write;
  assign wr.wr_addr   = in_write ? base + idx : 8'h00;
  assign wr.wr_data   = in_write ? rd_data : 8'h00;
  assign o_busy       = (state != ST_IDLE);
  assign o_dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      base        <= 8'h00;
      len         <= 8'h00;
      idx         <= 8'h00;
      tmo_cnt     <= '0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_overrun   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_acc     <= 8'h00;
`endif
    end else begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      tmo_cnt     <= (in_parse && !i_rx_done && !i_rx_receiving) ? tmo_cnt + TW'(1) : '0;

      // A byte arriving on the timeout cycle takes priority over the abort.
      if (in_parse && !i_rx_done && tmo_hit) begin
        state       <= ST_IDLE;
        o_frame_err <= 1'b1;
        o_err_code  <= ERR_TIMEOUT;
      end else begin
        case (state)
          ST_IDLE: begin
`ifdef UART_CMD_CHECKSUM_EN
            chk_acc <= 8'h00;
`endif
            if (i_rx_done && (i_rx_data == SYNC_BYTE)) state <= ST_ADDR;
          end
          ST_ADDR: begin
            if (i_rx_done) begin
              base  <= i_rx_data;
`ifdef UART_CMD_CHECKSUM_EN
              chk_acc <= chk_acc ^ i_rx_data;
`endif
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (i_rx_done) begin
              if ((i_rx_data == 8'h00) || (i_rx_data > MAX_LEN_B)) begin
                state       <= ST_IDLE;
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_LEN;
              end else begin
                len   <= i_rx_data;
                idx   <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
                chk_acc <= chk_acc ^ i_rx_data;
`endif
                state <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (i_rx_done) begin
`ifdef UART_CMD_CHECKSUM_EN
              chk_acc <= chk_acc ^ i_rx_data;
`endif
              if (last_idx) begin
                idx <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
                state <= ST_CHK;
`else
                state <= ST_WRITE;
`endif
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          ST_CHK: begin
            if (i_rx_done) begin
              if (i_rx_data == chk_acc) begin
                state <= ST_WRITE;
              end else begin
                state       <= ST_IDLE;
                o_frame_err <= 1'b1;
                o_err_code  <= ERR_CHK;
              end
            end
          end
`endif
          ST_WRITE: begin
            if (i_rx_done) o_overrun <= 1'b1;
            if (wr.wr_ready) begin
              if (last_idx) begin
                idx        <= 8'h00;
                state      <= ST_IDLE;
                o_frame_ok <= 1'b1;
              end else begin
                idx <= idx + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: directed frames from the test plan
// followed by randomized frames, checked by a write/event scoreboard.
module tb_uart_cmd_sequencer;

  localparam int CLK_RATE     = 1_000_000;
  localparam int BAUD_RATE    = 100_000;
  localparam int TIMEOUT_BITS = 20;
  localparam int MAX_LEN      = 16;
  localparam int TICKS        = (CLK_RATE / BAUD_RATE) * TIMEOUT_BITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_recv = 1'b0;
  logic       busy, frame_ok, frame_err, overrun;
  logic [1:0] err_code;
  logic [2:0] dbg_state;

  uart_cmd_sequencer_if wr_if ();

  uart_cmd_sequencer #(
    .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_done(rx_done), .i_rx_receiving(rx_recv),
    .wr(wr_if),
    .o_busy(busy), .o_frame_ok(frame_ok), .o_frame_err(frame_err),
    .o_err_code(err_code), .o_overrun(overrun), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         tests = 0;
  int         fails = 0;
  logic [15:0] exp_q[$];    // {addr, data} per expected write
  logic [2:0]  evt_q[$];    // {is_err, code}; 3'b000 = frame_ok
  int         ovr_seen = 0;
  int         ovr_exp  = 0;
  logic [1:0] last_code = 2'b00;
  logic [7:0] pay [256];
  logic [7:0] corrupt_mask = 8'h01;
  int         ready_mode = 0;   // 0 always, 1 four-cycle stall, 2 random, 3 never

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- write-port responder ----------------
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    wr_if.wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: wr_if.wr_ready = 1'b1;
        1: begin
          if (wr_if.wr_en) begin
            if (stall_cnt < 4) begin wr_if.wr_ready = 1'b0; stall_cnt++; end
            else begin wr_if.wr_ready = 1'b1; stall_cnt = 0; end
          end else begin
            wr_if.wr_ready = 1'b0;
            stall_cnt = 0;
          end
        end
        2: wr_if.wr_ready = 1'($urandom_range(0, 1));
        default: wr_if.wr_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic       prev_pending = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending)
        check("stall_hold", {wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data},
              {1'b1, prev_addr, prev_data});
      if (wr_if.wr_en && wr_if.wr_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got %h/%h expected none", wr_if.wr_addr, wr_if.wr_data);
        end else begin
          check("write", {wr_if.wr_addr, wr_if.wr_data}, exp_q.pop_front());
        end
      end
      if (frame_ok || frame_err) begin
        if (evt_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_event: got ok=%0b err=%0b code=%0h expected none",
                   frame_ok, frame_err, err_code);
        end else begin
          check("frame_event", {frame_err, frame_err ? err_code : 2'b00}, evt_q.pop_front());
        end
      end
      if (overrun) ovr_seen++;
      prev_pending = wr_if.wr_en && !wr_if.wr_ready;
      prev_addr    = wr_if.wr_addr;
      prev_data    = wr_if.wr_data;
    end
  end

  // ---------------- drivers (caller sits at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    rx_recv = 1'b0;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      rx_recv = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    rx_recv = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 3000) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", cycles);
    end
  endtask

  function automatic logic [7:0] frame_chk(input logic [7:0] base, input logic [7:0] len);
    logic [7:0] x;
    x = base ^ len;
    for (int i = 0; i < len; i++) x ^= pay[i];
    return x;
  endfunction

  // Reference model: predicted outcome of one frame from the frame rules.
  task automatic model_frame(input logic [7:0] base, input logic [7:0] len, input bit corrupt);
    if (len == 0 || len > MAX_LEN) begin
      evt_q.push_back(3'b101);
      last_code = 2'b01;
    end
`ifdef UART_CMD_CHECKSUM_EN
    else if (corrupt) begin
      evt_q.push_back(3'b111);
      last_code = 2'b11;
    end
`endif
    else begin
      for (int i = 0; i < len; i++) exp_q.push_back({8'((base + i) % 256), pay[i]});
      evt_q.push_back(3'b000);
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input logic [7:0] len,
                            input bit corrupt, input int gap_max);
    model_frame(base, len, corrupt);
    send_byte(8'hA5);
    idle($urandom_range(0, gap_max));
    send_byte(base);
    idle($urandom_range(0, gap_max));
    send_byte(len);
    if (len != 0 && len <= MAX_LEN) begin
      for (int i = 0; i < len; i++) begin
        idle($urandom_range(0, gap_max));
        send_byte(pay[i]);
      end
`ifdef UART_CMD_CHECKSUM_EN
      idle($urandom_range(0, gap_max));
      send_byte(corrupt ? (frame_chk(base, len) ^ corrupt_mask) : frame_chk(base, len));
`endif
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [7:0] len, junk;
    bit corrupt;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_in_rst",
          {wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, busy, frame_ok, frame_err, err_code, overrun, dbg_state}, 0);
    rst = 1'b0;
    idle(2);
    check("reset_outputs",
          {wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, busy, frame_ok, frame_err, err_code, overrun, dbg_state}, 0);

    // A: back-to-back writes with 1-cycle latency
    ready_mode = 0;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(8'h10, 8'd3, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      check("back_to_back_wr_en", wr_if.wr_en, 1'b1);
      @(posedge clk); #1;
    end
    check("ok_after_last_write", {frame_ok, wr_if.wr_en}, 2'b10);
    idle(2);

    // B: stalled writes with address wrap
    ready_mode = 1;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_frame(8'hFE, 8'd3, 1'b0, 2);
    wait_idle(n);
    check("stall_write_cycles", n, 15);
    ready_mode = 0;
    idle(2);

    // C: junk bytes ignored, LEN=0 rejected
    send_byte(8'h00); idle(2);
    send_byte(8'hFF); idle(2);
    check("junk_ignored_idle", busy, 1'b0);
    send_frame(8'h20, 8'd0, 1'b0, 1);
    wait_idle(n);
    check("len0_err_code", err_code, 2'b01);
    idle(2);

    // D: inter-byte timeout, exact latency
    pay[0] = 8'hAA;
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h02); send_byte(8'hAA);
    evt_q.push_back(3'b110);
    last_code = 2'b10;
    n = 0;
    while (n < TICKS + 10) begin
      @(posedge clk); #1;
      n++;
      if (frame_err) break;
    end
    check("timeout_latency", n, TICKS);
    check("timeout_err_code", err_code, 2'b10);
    check("timeout_idle", busy, 1'b0);
    idle(2);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_frame(8'h44, 8'd2, 1'b0, 2);
    wait_idle(n);
    idle(2);

`ifdef UART_CMD_CHECKSUM_EN
    // E: checksum mismatch then match
    pay[0] = 8'h55;
    corrupt_mask = 8'h74;
    send_frame(8'h20, 8'd1, 1'b1, 1);
    wait_idle(n);
    check("chk_err_code", err_code, 2'b11);
    idle(2);
    send_frame(8'h20, 8'd1, 1'b0, 1);
    wait_idle(n);
    idle(2);
`endif

    // F: byte during WRITE is dropped with overrun
    ready_mode = 3;
    pay[0] = 8'hC1; pay[1] = 8'hC2;
    send_frame(8'h30, 8'd2, 1'b0, 1);
    idle(2);
    check("stalled_in_write", wr_if.wr_en, 1'b1);
    send_byte(8'hA5);
    ovr_exp++;
    idle(2);
    ready_mode = 0;
    wait_idle(n);
    idle(1);
    send_byte(8'h40); send_byte(8'h01); send_byte(8'h77);
    idle(3);
    check("discarded_frame_ignored", busy, 1'b0);
    pay[0] = 8'h9E;
    send_frame(8'h60, 8'd1, 1'b0, 0);
    wait_idle(n);
    idle(2);

    // G: reset asserted mid-WRITE
    ready_mode = 3;
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h02);
    send_byte(8'hD1); send_byte(8'hD2);
    idle(2);
    check("pre_reset_write", wr_if.wr_en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("reset_mid_write",
          {wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, busy, frame_ok, frame_err, err_code, overrun}, 0);
    last_code = 2'b00;
    ready_mode = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // H: randomized frames
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk);
        idle($urandom_range(0, 2));
      end
      case ($urandom_range(0, 9))
        0: len = 8'd0;
        1: len = 8'($urandom_range(MAX_LEN + 1, 255));
        default: len = 8'($urandom_range(1, MAX_LEN));
      endcase
      for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom);
      corrupt = ($urandom_range(0, 3) == 0);
      corrupt_mask = 8'($urandom_range(1, 255));
      send_frame(8'($urandom), len, corrupt, 3);
      wait_idle(n);
      idle($urandom_range(0, 2));
    end

    idle(5);
    check("exp_writes_drained", exp_q.size(), 0);
    check("exp_events_drained", evt_q.size(), 0);
    check("overrun_count", ovr_seen, ovr_exp);
    check("final_err_code", err_code, last_code);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
